payload_to_dma_mc: RTL and testbench
====================================

Name: payload_to_dma_mc

Overview:
- Multi-channel successor to the single-register DMA command engine.
- Accepts DMA commands from N_CH independent channels and arbitrates among them round-robin.
- Emits a header beat plus real write payload taken from a source stream, with a byte-accurate last-beat tkeep.
- For reads, strips the echoed response header, forwards payload per channel, and reports per-command completion: status plus byte count.

Parameters:
DATA_BITS, 512, stream width; must be at least 128.
N_CH, 4, command channels; must be at least 2.
LEN_BITS, 32, byte-length field width.
KB (local), DATA_BITS/8, bytes per beat.
CH_BITS (local), clog2(N_CH).

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
cmd_valid  in  N_CH  per-channel command pending (level)
cmd_ready  out  N_CH  one-cycle grant pulse; command latched this cycle
cmd_dir  in  N_CH  1=write (h2d), 0=read
cmd_addr  in  64*N_CH  channel i address at [64i+:64]
cmd_len  in  LEN_BITS*N_CH  byte length per channel
done_valid  out  1  one-cycle completion pulse, no backpressure
done_ch  out  CH_BITS  completing channel
done_status  out  2  0=OK, 1=SHORT, 2=LONG
done_bytes  out  LEN_BITS  bytes transferred
mmio_output_active  in  1  MMIO owns the output mux; gate output tvalid
dma_output_active  out  1  high in HDR or WR_DATA
wr_tdata/wr_tvalid  in  DATA_BITS/1  write payload source; wr_tkeep is not present
wr_tready  out  1
out_tdata/out_tkeep/out_tvalid/out_tlast  out  DATA_BITS/KB/1/1  request stream
out_tuser  out  CH_BITS  channel id of the current beat
out_tready  in  1
rsp_tdata/rsp_tkeep/rsp_tvalid/rsp_tlast  in  DATA_BITS/KB/1/1  read response (header beat first)
rsp_tready  out  1
rd_tdata/rd_tkeep/rd_tvalid/rd_tlast  out  DATA_BITS/KB/1/1  stripped read payload
rd_tdest  out  CH_BITS
rd_tready  in  1

Behaviour:
- Reset: all outputs are 0, state is IDLE, RR pointer is 0, counters are 0. Reset mid-operation abandons the in-flight command with no done pulse.
- States: IDLE, HDR, WR_DATA, RD_HDR, RD_DATA, DONE.
- IDLE → grant: lowest index at or after ptr with cmd_valid. Pulse cmd_ready, latch dir/addr/len/ch, set ptr = granted+1 mod N_CH.
  - len==0: go to DONE with OK, bytes 0; no header is sent.
  - Otherwise go to HDR.
  - Grant takes 1 cycle; out_tvalid rises the cycle after grant.
- Header beat layout: [0]=dir, [15:8]=ch, [79:16]=addr, [80+:LEN_BITS]=len, rest 0.
  - tkeep = low ceil((80+LEN_BITS)/8) bytes; 14 bytes at default.
  - tlast = !dir. tuser = ch.
- Output gating: out_tvalid = beat_available && !mmio_output_active, where beat_available is 1 in HDR and equals wr_tvalid in WR_DATA.
  - A beat transfers only when out_tvalid && out_tready.
  - HDR → WR_DATA (write) or RD_HDR (read) on transfer.
- WR_DATA: beats = ceil(len/KB).
  - out_tdata = wr_tdata; wr_tready = out_tready && !mmio_output_active.
  - Non-last beats use full tkeep.
  - Last beat: tkeep = low (len mod KB) bytes, or all ones if the remainder is 0; tlast=1.
  - Last beat → DONE with OK, bytes = len.
  - Byte counter is LEN_BITS+1 wide; no wrap.
- RD_HDR: rsp_tready=1; the first rsp beat is discarded → RD_DATA.
  - If that header beat carries rsp_tlast: DONE with SHORT, bytes 0.
- RD_DATA: forward rsp to rd combinationally: rsp_tready = rd_tready, rd_tdest = ch.
  - count += popcount(rsp_tkeep) per transfer.
  - Once count ≥ len: further beats are consumed with rsp_tready=1 and dropped, and not forwarded (rd_tvalid=0).
  - rd_tlast = rsp_tlast, or on the beat where count reaches len, whichever comes first.
  - Only one outstanding command; no new grant until DONE.
- Status at rsp_tlast:
  - OK if total == len.
  - SHORT if total < len.
  - LONG if total > len; done_bytes = len.
- DONE: done_valid=1 for 1 cycle with done_ch, done_status, done_bytes → IDLE. The next grant is possible the following cycle.
- IDLE with stray rsp beats: rsp_tready=1, beats discarded, no done pulse.
- cmd_valid dropping before grant is legal; no grant is made.

Test Plan:
1. Write ch0, len=100, DATA_BITS=512 → header keep=0x3FFF, tlast=0, tuser=0; then 2 payload beats equal to wr_tdata, second keep=0x0000000FFFFFFFFF with tlast; done ch0, OK, bytes 100.
2. Read ch2, len=128; rsp = header + 2 full beats (tlast on third) → out header tlast=1 keep=0x3FFF; rd 2 beats with tdest=2, tlast on second; header never appears on rd; done OK, 128.
3. Read len=128; rsp = header + 1 full beat with tlast → done SHORT, 64. Read len=64 with 3 rsp beats → rd tlast on beat 1, extra beat dropped; done LONG, 64.
4. All 4 channels cmd_valid with len=64 writes → grant order 0,1,2,3. Then only ch0 and ch3 valid (ptr=0) → 0 then 3; each cmd_ready is a single pulse.
5. mmio_output_active held high 5 cycles mid-WR_DATA with out_tready=1 → out_tvalid=0 and wr_tready=0 throughout; payload order intact, no duplicate or lost beat. dma_output_active stays 1.
6. areset mid write beat 1 → next cycle all outputs 0; subsequent len=0 command → done OK, 0 with no out beat.

Source files
------------

// File: rtl/payload_to_dma_mc_if.sv
// rtl/payload_to_dma_mc_if.sv - command, completion and stream signals of the multi-channel DMA engine
interface payload_to_dma_mc_if #(
  parameter int DATA_BITS = 512,
  parameter int N_CH      = 4,
  parameter int LEN_BITS  = 32
);
  localparam int KB      = DATA_BITS / 8;
  localparam int CH_BITS = $clog2(N_CH);

  logic [N_CH-1:0]          cmd_valid;
  logic [N_CH-1:0]          cmd_ready;
  logic [N_CH-1:0]          cmd_dir;
  logic [64*N_CH-1:0]       cmd_addr;
  logic [LEN_BITS*N_CH-1:0] cmd_len;

  logic                done_valid;
  logic [CH_BITS-1:0]  done_ch;
  logic [1:0]          done_status;
  logic [LEN_BITS-1:0] done_bytes;

  logic mmio_output_active;
  logic dma_output_active;

  logic [DATA_BITS-1:0] wr_tdata;
  logic                 wr_tvalid;
  logic                 wr_tready;

  logic [DATA_BITS-1:0] out_tdata;
  logic [KB-1:0]        out_tkeep;
  logic                 out_tvalid;
  logic                 out_tlast;
  logic [CH_BITS-1:0]   out_tuser;
  logic                 out_tready;

  logic [DATA_BITS-1:0] rsp_tdata;
  logic [KB-1:0]        rsp_tkeep;
  logic                 rsp_tvalid;
  logic                 rsp_tlast;
  logic                 rsp_tready;

  logic [DATA_BITS-1:0] rd_tdata;
  logic [KB-1:0]        rd_tkeep;
  logic                 rd_tvalid;
  logic                 rd_tlast;
  logic [CH_BITS-1:0]   rd_tdest;
  logic                 rd_tready;

  // slave is the engine side, master is the surrounding system
  modport slave (
    input  cmd_valid, cmd_dir, cmd_addr, cmd_len, mmio_output_active,
           wr_tdata, wr_tvalid, out_tready,
           rsp_tdata, rsp_tkeep, rsp_tvalid, rsp_tlast, rd_tready,
    output cmd_ready, done_valid, done_ch, done_status, done_bytes, dma_output_active,
           wr_tready, out_tdata, out_tkeep, out_tvalid, out_tlast, out_tuser,
           rsp_tready, rd_tdata, rd_tkeep, rd_tvalid, rd_tlast, rd_tdest
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_addr, cmd_len, mmio_output_active,
           wr_tdata, wr_tvalid, out_tready,
           rsp_tdata, rsp_tkeep, rsp_tvalid, rsp_tlast, rd_tready,
    input  cmd_ready, done_valid, done_ch, done_status, done_bytes, dma_output_active,
           wr_tready, out_tdata, out_tkeep, out_tvalid, out_tlast, out_tuser,
           rsp_tready, rd_tdata, rd_tkeep, rd_tvalid, rd_tlast, rd_tdest
  );
endinterface

// File: rtl/payload_to_dma_mc.sv
// rtl/payload_to_dma_mc.sv - round-robin multi-channel DMA command engine with header, write payload and read strip
module payload_to_dma_mc #(
  parameter int DATA_BITS = 512,
  parameter int N_CH      = 4,
  parameter int LEN_BITS  = 32
) (
  input  logic                aclk,
  input  logic                areset,
  payload_to_dma_mc_if.slave  bus
);
  localparam int KB        = DATA_BITS / 8;
  localparam int CH_BITS   = $clog2(N_CH);
  localparam int CW        = LEN_BITS + 1;
  localparam int HDR_BYTES = (80 + LEN_BITS + 7) / 8;
  localparam logic [KB-1:0] HDR_KEEP = {{(KB-HDR_BYTES){1'b0}}, {HDR_BYTES{1'b1}}};

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_SHORT = 2'd1;
  localparam logic [1:0] ST_LONG  = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WR_DATA, S_RD_HDR, S_RD_DATA, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CH_BITS-1:0]  ptr_q, ptr_d;
  logic [CH_BITS-1:0]  ch_q, ch_d;
  logic                dir_q, dir_d;
  logic [63:0]         addr_q, addr_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          st_q, st_d;
  logic [LEN_BITS-1:0] bytes_q, bytes_d;

  logic                gnt_any;
  logic [CH_BITS-1:0]  gnt_idx;
  logic [CW-1:0]       pop, cnt_nxt, rem, total, len_ext;
  logic                wr_last, count_done, over;
  logic [KB-1:0]       last_keep;
  logic [DATA_BITS-1:0] hdr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      st_q    <= ST_OK;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      bytes_q <= bytes_d;
    end
  end

  // First pending channel at or after the pointer, wrapping around
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_any && bus.cmd_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[CH_BITS-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < KB; i++) pop = pop + CW'(bus.rsp_tkeep[i]);
    len_ext    = {1'b0, len_q};
    cnt_nxt    = cnt_q + pop;
    rem        = len_ext - cnt_q;
    wr_last    = (rem <= CW'(KB));
    count_done = (cnt_q >= len_ext);
    over       = (cnt_q > len_ext);
    total      = over ? cnt_q : cnt_nxt;
    for (int i = 0; i < KB; i++) last_keep[i] = (CW'(i) < rem);
    hdr                 = '0;
    hdr[0]              = dir_q;
    hdr[8 +: CH_BITS]   = ch_q;
    hdr[79:16]          = addr_q;
    hdr[80 +: LEN_BITS] = len_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    bytes_d = bytes_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          ch_d   = gnt_idx;
          dir_d  = bus.cmd_dir[gnt_idx];
          addr_d = bus.cmd_addr[64*int'(gnt_idx) +: 64];
          len_d  = bus.cmd_len[LEN_BITS*int'(gnt_idx) +: LEN_BITS];
          ptr_d  = (gnt_idx == CH_BITS'(N_CH-1)) ? '0 : gnt_idx + CH_BITS'(1);
          cnt_d  = '0;
          if (bus.cmd_len[LEN_BITS*int'(gnt_idx) +: LEN_BITS] == '0) begin
            st_d    = ST_OK;
            bytes_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (bus.out_tvalid && bus.out_tready) state_d = dir_q ? S_WR_DATA : S_RD_HDR;
      end
      S_WR_DATA: begin
        if (bus.out_tvalid && bus.out_tready) begin
          cnt_d = cnt_q + CW'(KB);
          if (wr_last) begin
            st_d    = ST_OK;
            bytes_d = len_q;
            state_d = S_DONE;
          end
        end
      end
      S_RD_HDR: begin
        if (bus.rsp_tvalid) begin
          if (bus.rsp_tlast) begin
            st_d    = ST_SHORT;
            bytes_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_RD_DATA;
          end
        end
      end
      S_RD_DATA: begin
        if (bus.rsp_tvalid && bus.rsp_tready) begin
          // Counting stops once past len: only the direction of the mismatch matters
          if (!over) cnt_d = cnt_nxt;
          if (bus.rsp_tlast) begin
            state_d = S_DONE;
            if (total == len_ext) begin
              st_d    = ST_OK;
              bytes_d = len_q;
            end else if (total < len_ext) begin
              st_d    = ST_SHORT;
              bytes_d = total[LEN_BITS-1:0];
            end else begin
              st_d    = ST_LONG;
              bytes_d = len_q;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready         = '0;
    bus.done_valid        = 1'b0;
    bus.done_ch           = '0;
    bus.done_status       = '0;
    bus.done_bytes        = '0;
    bus.dma_output_active = 1'b0;
    bus.wr_tready         = 1'b0;
    bus.out_tdata         = '0;
    bus.out_tkeep         = '0;
    bus.out_tvalid        = 1'b0;
    bus.out_tlast         = 1'b0;
    bus.out_tuser         = '0;
    bus.rsp_tready        = 1'b0;
    bus.rd_tdata          = '0;
    bus.rd_tkeep          = '0;
    bus.rd_tvalid         = 1'b0;
    bus.rd_tlast          = 1'b0;
    bus.rd_tdest          = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) bus.cmd_ready = N_CH'(1) << gnt_idx;
        bus.rsp_tready = bus.rsp_tvalid;
      end
      S_HDR: begin
        bus.dma_output_active = 1'b1;
        bus.out_tvalid        = !bus.mmio_output_active;
        bus.out_tdata         = hdr;
        bus.out_tkeep         = HDR_KEEP;
        bus.out_tlast         = !dir_q;
        bus.out_tuser         = ch_q;
      end
      S_WR_DATA: begin
        bus.dma_output_active = 1'b1;
        bus.out_tvalid        = bus.wr_tvalid && !bus.mmio_output_active;
        bus.out_tdata         = bus.wr_tdata;
        bus.out_tkeep         = wr_last ? last_keep : '1;
        bus.out_tlast         = wr_last;
        bus.out_tuser         = ch_q;
        bus.wr_tready         = bus.out_tready && !bus.mmio_output_active;
      end
      S_RD_HDR: bus.rsp_tready = 1'b1;
      S_RD_DATA: begin
        if (count_done) begin
          bus.rsp_tready = 1'b1;
        end else begin
          bus.rsp_tready = bus.rd_tready;
          bus.rd_tvalid  = bus.rsp_tvalid;
          bus.rd_tdata   = bus.rsp_tdata;
          bus.rd_tkeep   = bus.rsp_tkeep;
          bus.rd_tlast   = bus.rsp_tlast || (cnt_nxt >= len_ext);
          bus.rd_tdest   = ch_q;
        end
      end
      S_DONE: begin
        bus.done_valid  = 1'b1;
        bus.done_ch     = ch_q;
        bus.done_status = st_q;
        bus.done_bytes  = bytes_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_payload_to_dma_mc.sv
// tb/tb_payload_to_dma_mc.sv - scoreboard bench for the multi-channel DMA command engine
module tb_payload_to_dma_mc;
  localparam int DB = 512;
  localparam int NC = 4;
  localparam int LB = 32;

  typedef struct {
    logic [DB-1:0] data;
    logic [63:0]   keep;
    logic          last;
    logic [1:0]    id;
  } beat_t;

  typedef struct {
    logic [1:0]  ch;
    logic [1:0]  st;
    logic [31:0] bytes;
  } done_t;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  payload_to_dma_mc_if #(.DATA_BITS(DB), .N_CH(NC), .LEN_BITS(LB)) bus ();
  payload_to_dma_mc #(.DATA_BITS(DB), .N_CH(NC), .LEN_BITS(LB)) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_out[$];
  beat_t exp_rd[$];
  done_t exp_done[$];
  int    exp_grant[$];
  logic [NC-1:0] prev_ready = '0;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [DB-1:0] pat(input logic [31:0] s);
    return {16{s}};
  endfunction

  function automatic logic [DB-1:0] hdr_word(input bit dir, input logic [7:0] ch,
                                             input logic [63:0] addr, input logic [31:0] len);
    logic [DB-1:0] h;
    h          = '0;
    h[0]       = dir;
    h[15:8]    = ch;
    h[79:16]   = addr;
    h[111:80]  = len;
    return h;
  endfunction

  always @(negedge aclk) begin : mon
    beat_t b;
    done_t d;
    int    g;
    if (bus.cmd_ready != '0) begin
      chk("grant_single_pulse", prev_ready, '0);
      chk("grant_onehot", $onehot(bus.cmd_ready), 1);
      if (exp_grant.size() == 0) chk("grant_unexpected", bus.cmd_ready, '0);
      else begin
        g = exp_grant.pop_front();
        chk("grant_ch", bus.cmd_ready, 4'b1 << g);
      end
    end
    prev_ready = bus.cmd_ready;
    if (bus.out_tvalid && bus.out_tready) begin
      if (exp_out.size() == 0) chk("out_unexpected_beat", 1, 0);
      else begin
        b = exp_out.pop_front();
        chk("out_tdata", bus.out_tdata, b.data);
        chk("out_tkeep", bus.out_tkeep, b.keep);
        chk("out_tlast", bus.out_tlast, b.last);
        chk("out_tuser", bus.out_tuser, b.id);
      end
    end
    if (bus.rd_tvalid && bus.rd_tready) begin
      if (exp_rd.size() == 0) chk("rd_unexpected_beat", 1, 0);
      else begin
        b = exp_rd.pop_front();
        chk("rd_tdata", bus.rd_tdata, b.data);
        chk("rd_tkeep", bus.rd_tkeep, b.keep);
        chk("rd_tlast", bus.rd_tlast, b.last);
        chk("rd_tdest", bus.rd_tdest, b.id);
      end
    end
    if (bus.done_valid) begin
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d = exp_done.pop_front();
        chk("done_ch", bus.done_ch, d.ch);
        chk("done_status", bus.done_status, d.st);
        chk("done_bytes", bus.done_bytes, d.bytes);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_out(input logic [DB-1:0] data, input logic [63:0] keep, input bit last, input int id);
    beat_t b;
    b.data = data; b.keep = keep; b.last = last; b.id = 2'(id);
    exp_out.push_back(b);
  endtask

  task automatic push_rd(input logic [DB-1:0] data, input bit last, input int id);
    beat_t b;
    b.data = data; b.keep = '1; b.last = last; b.id = 2'(id);
    exp_rd.push_back(b);
  endtask

  task automatic push_done(input int ch, input logic [1:0] st, input logic [31:0] bytes);
    done_t d;
    d.ch = 2'(ch); d.st = st; d.bytes = bytes;
    exp_done.push_back(d);
  endtask

  task automatic expect_wr(input int ch, input logic [63:0] addr, input logic [31:0] len,
                           input int nbeats, input logic [63:0] lkeep, input int seed);
    exp_grant.push_back(ch);
    push_out(hdr_word(1'b1, 8'(ch), addr, len), 64'h3FFF, 1'b0, ch);
    for (int k = 0; k < nbeats; k++)
      push_out(pat(32'(seed + k)), (k == nbeats-1) ? lkeep : '1, k == nbeats-1, ch);
    push_done(ch, 2'd0, len);
  endtask

  task automatic set_cmd(input int ch, input bit dir, input logic [63:0] addr, input logic [31:0] len);
    bus.cmd_dir[ch]          = dir;
    bus.cmd_addr[ch*64 +: 64] = addr;
    bus.cmd_len[ch*32 +: 32]  = len;
    bus.cmd_valid[ch]        = 1'b1;
  endtask

  task automatic wait_grant(input int ch);
    int t = 0;
    while (t < 200) begin
      @(negedge aclk);
      if (bus.cmd_ready[ch]) break;
      t++;
    end
    chk("grant_wait_in_time", t < 200, 1);
    tick();
    bus.cmd_valid[ch] = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (t < 200) begin
      @(negedge aclk);
      if (bus.done_valid) break;
      t++;
    end
    chk("done_wait_in_time", t < 200, 1);
    tick();
  endtask

  task automatic wr_payload(input int seed, input int nbeats, input int mmio_at);
    for (int k = 0; k < nbeats; k++) begin
      int t = 0;
      bus.wr_tdata  = pat(32'(seed + k));
      bus.wr_tvalid = 1'b1;
      if (k == mmio_at) begin
        bus.mmio_output_active = 1'b1;
        repeat (5) begin
          @(negedge aclk);
          chk("mmio_out_tvalid", bus.out_tvalid, 0);
          chk("mmio_wr_tready", bus.wr_tready, 0);
          chk("mmio_dma_active", bus.dma_output_active, 1);
        end
        tick();
        bus.mmio_output_active = 1'b0;
      end
      while (t < 200) begin
        @(negedge aclk);
        if (bus.wr_tready) break;
        t++;
      end
      chk("wr_beat_in_time", t < 200, 1);
      tick();
    end
    bus.wr_tvalid = 1'b0;
  endtask

  task automatic send_rsp(input logic [DB-1:0] data, input logic [63:0] keep, input bit last);
    int t = 0;
    bus.rsp_tdata  = data;
    bus.rsp_tkeep  = keep;
    bus.rsp_tlast  = last;
    bus.rsp_tvalid = 1'b1;
    while (t < 200) begin
      @(negedge aclk);
      if (bus.rsp_tready) break;
      t++;
    end
    chk("rsp_beat_in_time", t < 200, 1);
    tick();
    bus.rsp_tvalid = 1'b0;
    bus.rsp_tlast  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, '0);
    chk({tag, "_done_valid"}, bus.done_valid, 0);
    chk({tag, "_done_bytes"}, bus.done_bytes, '0);
    chk({tag, "_out_tvalid"}, bus.out_tvalid, 0);
    chk({tag, "_out_tdata"}, bus.out_tdata, '0);
    chk({tag, "_out_tkeep"}, bus.out_tkeep, '0);
    chk({tag, "_wr_tready"}, bus.wr_tready, 0);
    chk({tag, "_rsp_tready"}, bus.rsp_tready, 0);
    chk({tag, "_rd_tvalid"}, bus.rd_tvalid, 0);
    chk({tag, "_dma_active"}, bus.dma_output_active, 0);
  endtask

  initial begin
    areset                 = 1'b1;
    bus.cmd_valid          = '0;
    bus.cmd_dir            = '0;
    bus.cmd_addr           = '0;
    bus.cmd_len            = '0;
    bus.mmio_output_active = 1'b0;
    bus.wr_tdata           = '0;
    bus.wr_tvalid          = 1'b0;
    bus.out_tready         = 1'b1;
    bus.rsp_tdata          = '0;
    bus.rsp_tkeep          = '0;
    bus.rsp_tvalid         = 1'b0;
    bus.rsp_tlast          = 1'b0;
    bus.rd_tready          = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    @(negedge aclk);
    check_zero("reset");
    tick();

    // stray response beat while idle is swallowed without a completion
    send_rsp(pat(32'h99), '1, 1'b1);

    // 1: write ch0, 100 bytes
    expect_wr(0, 64'h0000_1234_5678_9A00, 32'd100, 2, 64'h0000000FFFFFFFFF, 'h100);
    set_cmd(0, 1'b1, 64'h0000_1234_5678_9A00, 32'd100);
    wait_grant(0);
    wr_payload('h100, 2, -1);
    wait_done();

    // 2: read ch2, 128 bytes, exact response
    exp_grant.push_back(2);
    push_out(hdr_word(1'b0, 8'd2, 64'h0000_0000_0002_0000, 32'd128), 64'h3FFF, 1'b1, 2);
    push_rd(pat(32'h200), 1'b0, 2);
    push_rd(pat(32'h201), 1'b1, 2);
    push_done(2, 2'd0, 32'd128);
    set_cmd(2, 1'b0, 64'h0000_0000_0002_0000, 32'd128);
    wait_grant(2);
    send_rsp(pat(32'hDEAD_BEEF), 64'h3FFF, 1'b0);
    send_rsp(pat(32'h200), '1, 1'b0);
    send_rsp(pat(32'h201), '1, 1'b1);
    wait_done();

    // 3a: short read
    exp_grant.push_back(1);
    push_out(hdr_word(1'b0, 8'd1, 64'h3000, 32'd128), 64'h3FFF, 1'b1, 1);
    push_rd(pat(32'h300), 1'b1, 1);
    push_done(1, 2'd1, 32'd64);
    set_cmd(1, 1'b0, 64'h3000, 32'd128);
    wait_grant(1);
    send_rsp(pat(32'hDEAD_0001), 64'h3FFF, 1'b0);
    send_rsp(pat(32'h300), '1, 1'b1);
    wait_done();

    // 3b: long read, trailing beat dropped
    exp_grant.push_back(3);
    push_out(hdr_word(1'b0, 8'd3, 64'h3100, 32'd64), 64'h3FFF, 1'b1, 3);
    push_rd(pat(32'h310), 1'b1, 3);
    push_done(3, 2'd2, 32'd64);
    set_cmd(3, 1'b0, 64'h3100, 32'd64);
    wait_grant(3);
    send_rsp(pat(32'hDEAD_0002), 64'h3FFF, 1'b0);
    send_rsp(pat(32'h310), '1, 1'b0);
    send_rsp(pat(32'h311), '1, 1'b1);
    wait_done();

    // 4: round robin over all channels, then ch0 and ch3
    for (int c = 0; c < NC; c++) expect_wr(c, 64'h4000 + 64'(c*64), 32'd64, 1, '1, 'h400 + 16*c);
    for (int c = 0; c < NC; c++) set_cmd(c, 1'b1, 64'h4000 + 64'(c*64), 32'd64);
    for (int c = 0; c < NC; c++) begin
      wait_grant(c);
      wr_payload('h400 + 16*c, 1, -1);
      wait_done();
    end
    expect_wr(0, 64'h4800, 32'd64, 1, '1, 'h480);
    expect_wr(3, 64'h4900, 32'd64, 1, '1, 'h490);
    set_cmd(0, 1'b1, 64'h4800, 32'd64);
    set_cmd(3, 1'b1, 64'h4900, 32'd64);
    wait_grant(0);
    wr_payload('h480, 1, -1);
    wait_done();
    wait_grant(3);
    wr_payload('h490, 1, -1);
    wait_done();

    // 5: MMIO steals the output for 5 cycles mid-payload
    expect_wr(1, 64'h5000, 32'd256, 4, '1, 'h500);
    set_cmd(1, 1'b1, 64'h5000, 32'd256);
    wait_grant(1);
    wr_payload('h500, 4, 1);
    wait_done();

    // 6: reset while the second payload beat is stalled
    exp_grant.push_back(1);
    push_out(hdr_word(1'b1, 8'd1, 64'h6000, 32'd200), 64'h3FFF, 1'b0, 1);
    push_out(pat(32'h600), '1, 1'b0, 1);
    set_cmd(1, 1'b1, 64'h6000, 32'd200);
    wait_grant(1);
    wr_payload('h600, 1, -1);
    bus.out_tready = 1'b0;
    bus.wr_tdata   = pat(32'h601);
    bus.wr_tvalid  = 1'b1;
    @(negedge aclk);
    chk("stalled_dma_active", bus.dma_output_active, 1);
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    @(negedge aclk);
    check_zero("midreset");
    tick();
    bus.out_tready = 1'b1;
    bus.wr_tvalid  = 1'b0;
    exp_grant.push_back(2);
    push_done(2, 2'd0, 32'd0);
    set_cmd(2, 1'b1, 64'h7000, 32'd0);
    wait_grant(2);
    wait_done();

    repeat (5) tick();
    chk("exp_out_drained", exp_out.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    chk("exp_done_drained", exp_done.size(), 0);
    chk("exp_grant_drained", exp_grant.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
